// File: rtl/queue_1024_serializer_pkg.sv
// Shared constants and types for the wide-word serializer.
// Geometry defaults, beat order and the two-state EMPTY/SEND encoding.
package queue_1024_serializer_pkg;

    localparam int IN_WIDTH_DEF  = 1024;
    localparam int OUT_WIDTH_DEF = 64;
    localparam bit LSB_FIRST_DEF = 1'b1;
    localparam int BEATS_DEF     = IN_WIDTH_DEF / OUT_WIDTH_DEF;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int CNT_W_DEF = clog2(BEATS_DEF);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_e;

endpackage

// File: rtl/queue_1024_serializer.sv
// Purpose: splits each IN_WIDTH word into BEATS narrow beats on a ready/valid stream.
// Latency: first beat valid the cycle after enq fire; back-to-back words with no bubble.
// Backpressure: deq stall freezes all state; enq_ready only when idle or last beat fires.
module queue_1024_serializer
    import queue_1024_serializer_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter bit LSB_FIRST = LSB_FIRST_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  io_enq_bits,
    input  logic                 io_enq_valid,
    output logic                 io_enq_ready,
    output logic [OUT_WIDTH-1:0] io_deq_bits,
    output logic                 io_deq_valid,
    input  logic                 io_deq_ready,
    output logic                 io_deq_last
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = clog2(BEATS);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_bad_geometry
        $error("queue_1024_serializer: IN_WIDTH must be a multiple of OUT_WIDTH giving at least 2 beats");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [IN_WIDTH-1:0]  buf_q, buf_d;

    logic                 busy;
    logic                 last;
    logic                 enq_fire;
    logic                 deq_fire;
    logic [CNT_W-1:0]     sel;
    logic [OUT_WIDTH-1:0] slice_a [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_slice
        assign slice_a[g] = buf_q[g*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        busy = (state_q == SEND);
        last = busy && (beat_cnt_q == CNT_W'(BEATS - 1));
        sel  = LSB_FIRST ? beat_cnt_q : (CNT_W'(BEATS - 1) - beat_cnt_q);

        io_deq_valid = busy;
        io_deq_last  = last;
        // Idle output is forced to zero so a drained stream never shows stale data.
        io_deq_bits  = busy ? slice_a[sel] : '0;
        io_enq_ready = !busy || (io_deq_ready && last);

        enq_fire = io_enq_valid && io_enq_ready;
        deq_fire = io_deq_valid && io_deq_ready;
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        buf_d      = buf_q;
        case (state_q)
            EMPTY: begin
                if (enq_fire) begin
                    buf_d      = io_enq_bits;
                    beat_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (deq_fire) begin
                    if (!last) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end else if (enq_fire) begin
                        buf_d      = io_enq_bits;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = '0;
                        state_d    = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EMPTY;
            beat_cnt_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            buf_q      <= buf_d;
        end
    end

endmodule
